// File: rtl/exc_commit_if.sv
// Exception-commit bus: the exception record and ROB/branch/eret status going
// in, flush/redirect/EPC state coming out. The producer side uses master, the
// commit controller uses slave.
interface exc_commit_if #(
    parameter int INST_W = 6,
    parameter int PC_W   = 32
);
    logic              exc_valid;
    logic [INST_W-1:0] exc_inst_num;
    logic [15:0]       exc_handler_addr;
    logic [3:0]        exc_cause;
    logic [PC_W-1:0]   exc_pc;
    logic              rob_head_valid;
    logic [INST_W-1:0] rob_head_inst_num;
    logic              br_flush;
    logic [INST_W-1:0] br_inst_num;
    logic              eret_valid;

    logic              flush;
    logic              redirect_valid;
    logic [PC_W-1:0]   redirect_pc;
    logic [PC_W-1:0]   epc;
    logic [3:0]        cause;
    logic              in_handler;
    logic              exc_busy;

    modport master (
        output exc_valid, exc_inst_num, exc_handler_addr, exc_cause, exc_pc,
               rob_head_valid, rob_head_inst_num, br_flush, br_inst_num, eret_valid,
        input  flush, redirect_valid, redirect_pc, epc, cause, in_handler, exc_busy
    );

    modport slave (
        input  exc_valid, exc_inst_num, exc_handler_addr, exc_cause, exc_pc,
               rob_head_valid, rob_head_inst_num, br_flush, br_inst_num, eret_valid,
        output flush, redirect_valid, redirect_pc, epc, cause, in_handler, exc_busy
    );
endinterface

// File: rtl/exc_commit_ctrl.sv
// Exception commit controller. Holds the oldest outstanding exception record,
// commits it when its instruction reaches the ROB head (flush, save EPC/cause,
// redirect to handler) and handles return-from-exception back to EPC+4.
// Ages are measured relative to the ROB head so tag wrap-around is harmless.
module exc_commit_ctrl #(
    parameter int INST_W       = 6,
    parameter int PC_W         = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    exc_commit_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PENDING,
        S_FLUSH,
        S_REDIRECT,
        S_HANDLER,
        S_ERET
    } state_t;

    state_t            state_q;
    logic [INST_W-1:0] pend_tag_q;
    logic [15:0]       pend_handler_q;
    logic [3:0]        pend_cause_q;
    logic [PC_W-1:0]   pend_pc_q;
    logic [2:0]        cnt_q;
    logic              flush_q;
    logic              redirect_valid_q;
    logic [PC_W-1:0]   redirect_pc_q;
    logic [PC_W-1:0]   epc_q;
    logic [3:0]        cause_q;
    logic              in_handler_q;
    logic              busy_q;

    // Distances from the ROB head; smaller means older, valid across wrap.
    logic [INST_W-1:0] age_pend;
    logic [INST_W-1:0] age_exc;
    logic [INST_W-1:0] age_br;
    logic              exc_older;
    logic              exc_hit;
    logic              pend_hit;
    logic              squash;

    assign age_pend  = pend_tag_q - bus.rob_head_inst_num;
    assign age_exc   = bus.exc_inst_num - bus.rob_head_inst_num;
    assign age_br    = bus.br_inst_num - bus.rob_head_inst_num;
    assign exc_older = bus.exc_valid && (age_exc < age_pend);
    // A replacing exception already sitting at the head commits immediately.
    assign exc_hit   = exc_older && bus.rob_head_valid
                       && (bus.exc_inst_num == bus.rob_head_inst_num);
    assign pend_hit  = bus.rob_head_valid && (bus.rob_head_inst_num == pend_tag_q);
    // Only instructions strictly younger than the branch are squashed.
    assign squash    = bus.br_flush && (age_pend > age_br);

    // Commit FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= S_IDLE;
            pend_tag_q       <= '0;
            pend_handler_q   <= '0;
            pend_cause_q     <= '0;
            pend_pc_q        <= '0;
            cnt_q            <= '0;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            epc_q            <= '0;
            cause_q          <= 4'h0;
            in_handler_q     <= 1'b0;
            busy_q           <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.exc_valid) begin
                        pend_tag_q     <= bus.exc_inst_num;
                        pend_handler_q <= bus.exc_handler_addr;
                        pend_cause_q   <= bus.exc_cause;
                        pend_pc_q      <= bus.exc_pc;
                        state_q        <= S_PENDING;
                        busy_q         <= 1'b1;
                    end
                end
                S_PENDING: begin
                    // Priority: head match, then branch squash, then replacement.
                    if (pend_hit || exc_hit) begin
                        if (exc_hit) begin
                            epc_q          <= bus.exc_pc;
                            cause_q        <= bus.exc_cause;
                            pend_handler_q <= bus.exc_handler_addr;
                        end else begin
                            epc_q   <= pend_pc_q;
                            cause_q <= pend_cause_q;
                        end
                        flush_q <= 1'b1;
                        cnt_q   <= 3'd1;
                        state_q <= S_FLUSH;
                    end else if (squash) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (exc_older) begin
                        pend_tag_q     <= bus.exc_inst_num;
                        pend_handler_q <= bus.exc_handler_addr;
                        pend_cause_q   <= bus.exc_cause;
                        pend_pc_q      <= bus.exc_pc;
                    end
                end
                S_FLUSH: begin
                    if (cnt_q == 3'(FLUSH_CYCLES)) begin
                        flush_q          <= 1'b0;
                        redirect_valid_q <= 1'b1;
                        redirect_pc_q    <= PC_W'(pend_handler_q);
                        state_q          <= S_REDIRECT;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                S_REDIRECT: begin
                    redirect_valid_q <= 1'b0;
                    in_handler_q     <= 1'b1;
                    state_q          <= S_HANDLER;
                end
                S_HANDLER: begin
                    // Nested exceptions are not taken while in the handler.
                    if (bus.eret_valid) begin
                        redirect_valid_q <= 1'b1;
                        redirect_pc_q    <= epc_q + PC_W'(4);
                        flush_q          <= 1'b1;
                        state_q          <= S_ERET;
                    end
                end
                S_ERET: begin
                    redirect_valid_q <= 1'b0;
                    flush_q          <= 1'b0;
                    in_handler_q     <= 1'b0;
                    busy_q           <= 1'b0;
                    state_q          <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.flush          = flush_q;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.epc            = epc_q;
    assign bus.cause          = cause_q;
    assign bus.in_handler     = in_handler_q;
    assign bus.exc_busy       = busy_q;

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Bench for exc_commit_ctrl: directed scenarios, a schedule-based reference
// model checked every cycle, and literal spot checks at key points.
module tb_exc_commit_ctrl;

    localparam int INST_W       = 6;
    localparam int PC_W         = 32;
    localparam int FLUSH_CYCLES = 2;
    localparam int TAGS         = 1 << INST_W;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    exc_commit_if #(.INST_W(INST_W), .PC_W(PC_W)) bus();

    exc_commit_ctrl #(
        .INST_W(INST_W), .PC_W(PC_W), .FLUSH_CYCLES(FLUSH_CYCLES)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [5:0]  tag;
        logic [15:0] h;
        logic [3:0]  c;
        logic [31:0] pc;
    } rec_t;

    typedef struct packed {
        logic        fl;
        logic        rv;
        logic [31:0] rpc;
        logic        inh;
        logic        busy;
    } outv_t;

    typedef enum {M_IDLE, M_PEND, M_SEQ, M_HANDLER} mphase_t;

    mphase_t     m_phase = M_IDLE;
    mphase_t     m_after = M_IDLE;
    rec_t        m_pend  = '0;
    outv_t       sched[$];
    logic        exp_fl = 0, exp_rv = 0, exp_inh = 0, exp_busy = 0;
    logic [31:0] exp_rpc = 0, exp_epc = 0;
    logic [3:0]  exp_cause = 0;

    function automatic int age(input int x, input int h);
        return ((x - h) % TAGS + TAGS) % TAGS;
    endfunction

    function automatic outv_t mk(input logic fl, input logic rv, input logic [31:0] rpc,
                                 input logic inh, input logic busy);
        outv_t o;
        o.fl = fl; o.rv = rv; o.rpc = rpc; o.inh = inh; o.busy = busy;
        return o;
    endfunction

    // Take the next scheduled output vector, or settle into the follow-on phase.
    task automatic apply_next();
        outv_t e;
        if (sched.size() > 0) begin
            e = sched.pop_front();
            exp_fl = e.fl; exp_rv = e.rv; exp_inh = e.inh; exp_busy = e.busy;
            if (e.rv) exp_rpc = e.rpc;
        end else begin
            m_phase  = m_after;
            exp_fl   = 0;
            exp_rv   = 0;
            exp_inh  = (m_after == M_HANDLER);
            exp_busy = (m_after != M_IDLE);
        end
    endtask

    task automatic model_step();
        int   ap, ae, ab, head;
        bit   newer_ok, commit;
        rec_t win, inc;
        head = int'(bus.rob_head_inst_num);
        inc  = {bus.exc_inst_num, bus.exc_handler_addr, bus.exc_cause, bus.exc_pc};
        case (m_phase)
            M_IDLE: if (bus.exc_valid) begin
                m_pend = inc; m_phase = M_PEND; exp_busy = 1;
            end
            M_PEND: begin
                ap = age(int'(m_pend.tag), head);
                ae = age(int'(bus.exc_inst_num), head);
                ab = age(int'(bus.br_inst_num), head);
                newer_ok = bus.exc_valid && (ae < ap);
                commit = 0;
                win = m_pend;
                if (bus.rob_head_valid && ap == 0) commit = 1;
                else if (newer_ok && bus.rob_head_valid && ae == 0) begin
                    commit = 1; win = inc;
                end
                if (commit) begin
                    exp_epc = win.pc; exp_cause = win.c;
                    for (int i = 0; i < FLUSH_CYCLES; i++) sched.push_back(mk(1, 0, 0, 0, 1));
                    sched.push_back(mk(0, 1, {16'h0, win.h}, 0, 1));
                    m_after = M_HANDLER; m_phase = M_SEQ;
                    apply_next();
                end else if (bus.br_flush && ap > ab) begin
                    m_phase = M_IDLE; exp_busy = 0;
                end else if (newer_ok) begin
                    m_pend = inc;
                end
            end
            M_SEQ: apply_next();
            M_HANDLER: if (bus.eret_valid) begin
                sched.push_back(mk(1, 1, exp_epc + 32'd4, 1, 1));
                m_after = M_IDLE; m_phase = M_SEQ;
                apply_next();
            end
            default: m_phase = M_IDLE;
        endcase
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_phase = M_IDLE; m_after = M_IDLE; m_pend = '0; sched.delete();
            exp_fl = 0; exp_rv = 0; exp_inh = 0; exp_busy = 0;
            exp_rpc = 0; exp_epc = 0; exp_cause = 0;
        end else begin
            model_step();
        end
    end

    // Per-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        check("flush", 32'(bus.flush), 32'(exp_fl));
        check("redirect_valid", 32'(bus.redirect_valid), 32'(exp_rv));
        if (exp_rv) check("redirect_pc", bus.redirect_pc, exp_rpc);
        check("epc", bus.epc, exp_epc);
        check("cause", 32'(bus.cause), 32'(exp_cause));
        check("in_handler", 32'(bus.in_handler), 32'(exp_inh));
        check("exc_busy", 32'(bus.exc_busy), 32'(exp_busy));
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_exc(input logic [5:0] tag, input logic [15:0] h,
                             input logic [3:0] c, input logic [31:0] pc);
        bus.exc_valid = 1; bus.exc_inst_num = tag; bus.exc_handler_addr = h;
        bus.exc_cause = c; bus.exc_pc = pc;
    endtask

    task automatic do_eret();
        bus.eret_valid = 1; cyc(1); bus.eret_valid = 0; cyc(1);
    endtask

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: got timeout want finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        bus.exc_valid = 0; bus.exc_inst_num = 0; bus.exc_handler_addr = 0;
        bus.exc_cause = 0; bus.exc_pc = 0; bus.rob_head_valid = 0;
        bus.rob_head_inst_num = 0; bus.br_flush = 0; bus.br_inst_num = 0;
        bus.eret_valid = 0;
        cyc(2);
        check("rst_flush", 32'(bus.flush), 0);
        check("rst_busy", 32'(bus.exc_busy), 0);
        check("rst_epc", bus.epc, 0);
        rst_n = 1;
        cyc(1);

        // Single exception, then a nested attempt in the handler, then eret.
        bus.rob_head_valid = 1; bus.rob_head_inst_num = 3;
        drive_exc(5, 16'h030C, 2, 32'h100); cyc(1); bus.exc_valid = 0;
        check("t1_busy", 32'(bus.exc_busy), 1);
        bus.rob_head_inst_num = 4; cyc(2);
        bus.rob_head_inst_num = 5; cyc(1);
        check("t1_flush", 32'(bus.flush), 1);
        check("t1_epc", bus.epc, 32'h100);
        check("t1_cause", 32'(bus.cause), 2);
        check("t1_model_epc", exp_epc, 32'h100);
        bus.rob_head_inst_num = 6; cyc(1);
        check("t1_flush2", 32'(bus.flush), 1);
        cyc(1);
        check("t1_rv", 32'(bus.redirect_valid), 1);
        check("t1_rpc", bus.redirect_pc, 32'h0000030C);
        check("t1_model_rpc", exp_rpc, 32'h0000030C);
        check("t1_noflush", 32'(bus.flush), 0);
        cyc(1);
        check("t1_inh", 32'(bus.in_handler), 1);
        drive_exc(6, 16'h0AAA, 1, 32'h300); cyc(2); bus.exc_valid = 0;
        check("t1_nested_flush", 32'(bus.flush), 0);
        check("t1_nested_epc", bus.epc, 32'h100);
        bus.eret_valid = 1; cyc(1); bus.eret_valid = 0;
        check("t1_eret_rpc", bus.redirect_pc, 32'h104);
        check("t1_eret_flush", 32'(bus.flush), 1);
        cyc(1);
        check("t1_idle_inh", 32'(bus.in_handler), 0);
        check("t1_idle_busy", 32'(bus.exc_busy), 0);

        // Older replaces younger across tag wrap.
        bus.rob_head_inst_num = 60;
        drive_exc(2, 16'h0222, 1, 32'h200); cyc(1);
        drive_exc(62, 16'h0666, 3, 32'h600); cyc(1); bus.exc_valid = 0;
        bus.rob_head_inst_num = 61; cyc(1);
        bus.rob_head_inst_num = 62; cyc(1);
        check("t2_flush", 32'(bus.flush), 1);
        check("t2_epc", bus.epc, 32'h600);
        check("t2_cause", 32'(bus.cause), 3);
        bus.rob_head_inst_num = 63; cyc(2);
        check("t2_rpc", bus.redirect_pc, 32'h666);
        cyc(1); do_eret();

        // Mispredict squash vs. keep.
        bus.rob_head_inst_num = 8;
        drive_exc(10, 16'h0100, 0, 32'h400); cyc(1); bus.exc_valid = 0;
        bus.br_flush = 1; bus.br_inst_num = 9; cyc(1); bus.br_flush = 0;
        check("t3_squash_busy", 32'(bus.exc_busy), 0);
        drive_exc(10, 16'h0100, 0, 32'h400); cyc(1); bus.exc_valid = 0;
        bus.br_flush = 1; bus.br_inst_num = 10; cyc(1); bus.br_flush = 0;
        check("t3_keep_busy", 32'(bus.exc_busy), 1);
        cyc(1);
        check("t3_noflush", 32'(bus.flush), 0);
        bus.rob_head_inst_num = 10; cyc(1);
        check("t3_flush", 32'(bus.flush), 1);
        check("t3_epc", bus.epc, 32'h400);
        cyc(2);
        check("t3_rpc", bus.redirect_pc, 32'h100);
        cyc(1); do_eret();

        // Eret with EPC+4 wrapping to zero.
        bus.rob_head_inst_num = 19;
        drive_exc(20, 16'h0FF0, 3, 32'hFFFF_FFFC); cyc(1); bus.exc_valid = 0;
        bus.rob_head_inst_num = 20; cyc(1);
        check("t4_epc", bus.epc, 32'hFFFF_FFFC);
        cyc(3);
        check("t4_inh", 32'(bus.in_handler), 1);
        bus.eret_valid = 1; cyc(1); bus.eret_valid = 0;
        check("t4_rv", 32'(bus.redirect_valid), 1);
        check("t4_rpc", bus.redirect_pc, 32'h0);
        check("t4_flush", 32'(bus.flush), 1);
        cyc(1);
        check("t4_inh0", 32'(bus.in_handler), 0);
        check("t4_busy0", 32'(bus.exc_busy), 0);
        check("t4_flush0", 32'(bus.flush), 0);

        // Head match beats simultaneous branch flush and new exception.
        bus.rob_head_inst_num = 2;
        drive_exc(4, 16'h0444, 2, 32'h440); cyc(1);
        bus.rob_head_inst_num = 4; bus.br_flush = 1; bus.br_inst_num = 3;
        drive_exc(3, 16'h0333, 1, 32'h330); cyc(1);
        bus.exc_valid = 0; bus.br_flush = 0;
        check("t5_flush", 32'(bus.flush), 1);
        check("t5_epc", bus.epc, 32'h440);
        check("t5_cause", 32'(bus.cause), 2);
        cyc(2);
        check("t5_rpc", bus.redirect_pc, 32'h444);
        cyc(1); do_eret();

        // Replacing exception already at head commits directly.
        bus.rob_head_inst_num = 10;
        drive_exc(12, 16'h0121, 1, 32'h120); cyc(1);
        bus.rob_head_inst_num = 11;
        drive_exc(11, 16'h0111, 0, 32'h110); cyc(1); bus.exc_valid = 0;
        check("t6_flush", 32'(bus.flush), 1);
        check("t6_epc", bus.epc, 32'h110);
        check("t6_cause", 32'(bus.cause), 0);
        cyc(2);
        check("t6_rpc", bus.redirect_pc, 32'h111);
        cyc(1); do_eret();

        // Async reset during the first flush cycle.
        bus.rob_head_inst_num = 6;
        drive_exc(7, 16'h0777, 3, 32'h700); cyc(1); bus.exc_valid = 0;
        bus.rob_head_inst_num = 7; cyc(1);
        check("t7_flush", 32'(bus.flush), 1);
        #1 rst_n = 0;
        #1;
        check("t7_rst_flush", 32'(bus.flush), 0);
        check("t7_rst_rv", 32'(bus.redirect_valid), 0);
        check("t7_rst_busy", 32'(bus.exc_busy), 0);
        check("t7_rst_epc", bus.epc, 0);
        check("t7_rst_cause", 32'(bus.cause), 0);
        check("t7_rst_rpc", bus.redirect_pc, 0);
        cyc(1);
        #2 rst_n = 1;
        cyc(4);
        check("t7_after_rv", 32'(bus.redirect_valid), 0);
        check("t7_after_busy", 32'(bus.exc_busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/exc_commit_ctrl.md
Name: exc_commit_ctrl

Overview:
- Sits directly downstream of the interrupt vector table stage.
- Captures the registered exception record (handler address, cause, instruction number, PC), keeps the oldest outstanding exception, and waits until that instruction reaches the reorder-buffer head.
- Then flushes the pipeline, latches EPC/cause and redirects fetch to the handler.
- Also handles return-from-exception back to EPC+4.

Parameters:
- INST_W, 6: width of the instruction number (ROB tag); wrap-around modulo 2^INST_W.
- PC_W, 32: program-counter width; the 16-bit handler address is zero-extended to it.
- FLUSH_CYCLES, 2: number of cycles flush is held high (1..7).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- exc_valid  in  1  exception record valid this cycle (registered output of vector stage).
- exc_inst_num  in  INST_W  ROB tag of the faulting instruction.
- exc_handler_addr  in  16  handler entry address.
- exc_cause  in  4  cause code (0 illegal, 1 LS, 2 div-by-0, 3 address).
- exc_pc  in  PC_W  PC of the faulting instruction.
- rob_head_valid  in  1  ROB head holds a valid instruction.
- rob_head_inst_num  in  INST_W  ROB tag at the head.
- br_flush  in  1  branch-mispredict flush this cycle.
- br_inst_num  in  INST_W  ROB tag of the mispredicted branch.
- eret_valid  in  1  return-from-exception committed.
- flush  out  1  pipeline flush, held FLUSH_CYCLES cycles.
- redirect_valid  out  1  one-cycle fetch-redirect pulse.
- redirect_pc  out  PC_W  redirect target, valid with redirect_valid.
- epc  out  PC_W  saved exception PC.
- cause  out  4  saved cause.
- in_handler  out  1  high from redirect-to-handler until eret.
- exc_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0): state IDLE; flush, redirect_valid, in_handler, exc_busy = 0; redirect_pc, epc = 0; cause = 4'h0; pending record cleared.
- Age: age(x) = (x - rob_head_inst_num) mod 2^INST_W; smaller age is older. The comparison must be correct across tag wrap.
- IDLE:
  - exc_valid=1 → latch record (tag, handler, cause, pc) → PENDING, next cycle.
  - eret_valid is ignored.
- PENDING:
  - exc_valid with age(exc_inst_num) < age(pending tag) → replace record. Equal or younger → discard.
  - br_flush with age(pending tag) > age(br_inst_num) → pending is squashed → IDLE. Equal age (the branch itself) → keep.
  - rob_head_valid && rob_head_inst_num == pending tag → FLUSH. In the same edge: epc ← pending pc, cause ← pending cause, flush ← 1.
  - Priority in one cycle: head-match > br_flush > new exc_valid.
  - A replacing exc_valid that itself matches the head in the same cycle is used directly.
- FLUSH:
  - flush held high for exactly FLUSH_CYCLES cycles, counted by an internal counter.
  - exc_valid, br_flush and eret_valid are ignored.
  - On the last cycle → REDIRECT.
- REDIRECT:
  - One cycle: redirect_valid=1, redirect_pc = zero-extended handler address, flush=0.
  - in_handler ← 1 at the end of the cycle → HANDLER.
- HANDLER:
  - exc_valid is ignored (no nesting); eret_valid → ERET.
- ERET:
  - One cycle: redirect_valid=1, redirect_pc = epc+4 (mod 2^PC_W), flush=1 for this one cycle.
  - in_handler ← 0 → IDLE.
- Latency: head-match edge → flush at +1 cycle. redirect_valid follows at +1+FLUSH_CYCLES. eret_valid → redirect at +1.
- All outputs are registered.
- epc and cause hold their values until the next exception commit.
- exc_busy = (state != IDLE).

Test Plan:
- Single exception: exc_valid, tag 5, handler 16'h030C, cause 2, pc 32'h100; head reaches 5 three cycles later → flush high 2 cycles, then redirect_valid with redirect_pc=32'h0000030C; epc=32'h100, cause=2, in_handler=1.
- Older replaces younger: head=60 (INST_W=6); exc tag 2 then exc tag 62 → tag 62 kept (age 2 < 6); head hits 62 → commit; tag 2's record is never used.
- Mispredict squash: pending tag 10, head 8, br_flush br_inst_num=9 → IDLE, no flush; repeat with br_inst_num=10 → pending retained.
- Eret: in HANDLER with epc=32'hFFFF_FFFC, eret_valid → redirect_pc=32'h0 (wrap), flush one cycle, in_handler=0, state IDLE.
- Simultaneous events: in PENDING with tag 4 at head, also br_flush (br_inst_num=3) and exc_valid tag 3 in the same cycle → commit of tag 4 wins. Exception during HANDLER is ignored.
- Reset mid-FLUSH: rst_n low during the first flush cycle → all outputs 0 immediately (async); no redirect after release.
